// File: rtl/spi_slave_axi_mem.sv
// AXI4 slave scratch memory: independent write (AW/W/B) and read (AR/R) engines
// sharing one word array, INCR bursts only, SLVERR for beats beyond the array.
module spi_slave_axi_mem #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 3,
  parameter int MEM_WORDS      = 1024
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic                          axi_slave_aw_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_slave_aw_addr,
  input  logic [7:0]                    axi_slave_aw_len,
  input  logic [AXI_ID_WIDTH-1:0]       axi_slave_aw_id,
  output logic                          axi_slave_aw_ready,
  input  logic                          axi_slave_w_valid,
  input  logic [AXI_DATA_WIDTH-1:0]     axi_slave_w_data,
  input  logic [AXI_DATA_WIDTH/8-1:0]   axi_slave_w_strb,
  output logic                          axi_slave_w_ready,
  output logic                          axi_slave_b_valid,
  output logic [1:0]                    axi_slave_b_resp,
  output logic [AXI_ID_WIDTH-1:0]       axi_slave_b_id,
  input  logic                          axi_slave_b_ready,
  input  logic                          axi_slave_ar_valid,
  input  logic [AXI_ADDR_WIDTH-1:0]     axi_slave_ar_addr,
  input  logic [7:0]                    axi_slave_ar_len,
  input  logic [AXI_ID_WIDTH-1:0]       axi_slave_ar_id,
  output logic                          axi_slave_ar_ready,
  output logic                          axi_slave_r_valid,
  output logic [AXI_DATA_WIDTH-1:0]     axi_slave_r_data,
  output logic [1:0]                    axi_slave_r_resp,
  output logic                          axi_slave_r_last,
  output logic [AXI_ID_WIDTH-1:0]       axi_slave_r_id,
  input  logic                          axi_slave_r_ready
);

  localparam int AW   = AXI_ADDR_WIDTH;
  localparam int DW   = AXI_DATA_WIDTH;
  localparam int IDW  = AXI_ID_WIDTH;
  localparam int NB   = DW / 8;
  localparam int OFF  = $clog2(NB);
  localparam int IDXW = $clog2(MEM_WORDS);
  localparam int TOPB = OFF + IDXW;
  localparam logic [AW-1:0] STEP = AW'(NB);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WIDLE, WDATA, WRESP} wstate_t;
  typedef enum logic [1:0] {RIDLE, RFETCH, RDATA} rstate_t;

  function automatic logic in_range(input logic [AW-1:0] a);
    return (a >> TOPB) == '0;
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [AW-1:0] a);
    return a[OFF +: IDXW];
  endfunction

  logic [DW-1:0] mem [MEM_WORDS];

  wstate_t        w_state, w_state_nx;
  logic [AW-1:0]  wr_addr;
  logic [7:0]     wr_len, wr_beat;
  logic [IDW-1:0] wr_id;
  logic           wr_err;
  logic           aw_hs, w_hs, mem_we;

  rstate_t        r_state, r_state_nx;
  logic [AW-1:0]  rd_addr;
  logic [7:0]     rd_len, rd_beat;
  logic [IDW-1:0] rd_id;
  logic           rd_err;
  logic [DW-1:0]  rd_q;
  logic           ar_hs, r_hs, rd_last;

  assign aw_hs   = axi_slave_aw_valid & axi_slave_aw_ready;
  assign w_hs    = axi_slave_w_valid & axi_slave_w_ready;
  assign mem_we  = w_hs & in_range(wr_addr);
  assign ar_hs   = axi_slave_ar_valid & axi_slave_ar_ready;
  assign r_hs    = axi_slave_r_valid & axi_slave_r_ready;
  assign rd_last = (rd_beat == rd_len);

  // Write engine
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) w_state <= WIDLE;
    else              w_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx         = w_state;
    axi_slave_aw_ready = 1'b0;
    axi_slave_w_ready  = 1'b0;
    axi_slave_b_valid  = 1'b0;
    axi_slave_b_resp   = RESP_OKAY;
    axi_slave_b_id     = '0;
    case (w_state)
      WIDLE: begin
        axi_slave_aw_ready = 1'b1;
        if (axi_slave_aw_valid) w_state_nx = WDATA;
      end
      WDATA: begin
        axi_slave_w_ready = 1'b1;
        if (axi_slave_w_valid && wr_beat == wr_len) w_state_nx = WRESP;
      end
      WRESP: begin
        axi_slave_b_valid = 1'b1;
        axi_slave_b_resp  = wr_err ? RESP_SLVERR : RESP_OKAY;
        axi_slave_b_id    = wr_id;
        if (axi_slave_b_ready) w_state_nx = WIDLE;
      end
      default: w_state_nx = WIDLE;
    endcase
  end

  // Burst bookkeeping is re-initialised on every address handshake, so it needs no reset
  always_ff @(posedge axi_aclk) begin
    if (aw_hs) begin
      wr_addr <= axi_slave_aw_addr;
      wr_len  <= axi_slave_aw_len;
      wr_id   <= axi_slave_aw_id;
      wr_beat <= 8'd0;
      wr_err  <= 1'b0;
    end else if (w_hs) begin
      wr_addr <= wr_addr + STEP;
      wr_beat <= wr_beat + 8'd1;
      if (!in_range(wr_addr)) wr_err <= 1'b1;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (axi_slave_w_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= axi_slave_w_data[8*i +: 8];
      end
    end
  end

  // Read engine
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) r_state <= RIDLE;
    else              r_state <= r_state_nx;
  end

  always_comb begin
    r_state_nx         = r_state;
    axi_slave_ar_ready = 1'b0;
    axi_slave_r_valid  = 1'b0;
    axi_slave_r_last   = 1'b0;
    axi_slave_r_data   = '0;
    axi_slave_r_resp   = RESP_OKAY;
    axi_slave_r_id     = '0;
    case (r_state)
      RIDLE: begin
        axi_slave_ar_ready = 1'b1;
        if (axi_slave_ar_valid) r_state_nx = RFETCH;
      end
      RFETCH: r_state_nx = RDATA;
      RDATA: begin
        axi_slave_r_valid = 1'b1;
        axi_slave_r_last  = rd_last;
        axi_slave_r_data  = rd_q;
        axi_slave_r_resp  = rd_err ? RESP_SLVERR : RESP_OKAY;
        axi_slave_r_id    = rd_id;
        if (axi_slave_r_ready) r_state_nx = rd_last ? RIDLE : RFETCH;
      end
      default: r_state_nx = RIDLE;
    endcase
  end

  // A same-cycle write to the fetched word lands after this read samples the old value
  always_ff @(posedge axi_aclk) begin
    if (ar_hs) begin
      rd_addr <= axi_slave_ar_addr;
      rd_len  <= axi_slave_ar_len;
      rd_id   <= axi_slave_ar_id;
      rd_beat <= 8'd0;
      rd_err  <= 1'b0;
    end else if (r_state == RFETCH) begin
      rd_q <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
      if (!in_range(rd_addr)) rd_err <= 1'b1;
    end else if (r_hs && !rd_last) begin
      rd_addr <= rd_addr + STEP;
      rd_beat <= rd_beat + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_slave_axi_mem.sv
// Randomized self-checking bench for spi_slave_axi_mem against a byte-level
// memory model with sticky per-burst error tracking.
module tb_spi_slave_axi_mem;

  localparam int WORDS = 1024;
  localparam int NB    = 8;
  localparam logic [31:0] LIMIT = 32'(WORDS * NB);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        aw_valid = 1'b0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_id = '0;
  logic        aw_ready;
  logic        w_valid = 1'b0;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_ready;
  logic        b_valid;
  logic [1:0]  b_resp;
  logic [2:0]  b_id;
  logic        b_ready = 1'b0;
  logic        ar_valid = 1'b0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_id = '0;
  logic        ar_ready;
  logic        r_valid;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
  logic [2:0]  r_id;
  logic        r_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_mem [WORDS];
  logic [63:0] wdat [256];
  logic [7:0]  wstb [256];
  logic [63:0] last_rdata;
  time         r_done_time, b_done_time;

  always #5 clk = ~clk;

  spi_slave_axi_mem dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .axi_slave_aw_valid(aw_valid), .axi_slave_aw_addr(aw_addr), .axi_slave_aw_len(aw_len),
    .axi_slave_aw_id(aw_id), .axi_slave_aw_ready(aw_ready),
    .axi_slave_w_valid(w_valid), .axi_slave_w_data(w_data), .axi_slave_w_strb(w_strb),
    .axi_slave_w_ready(w_ready),
    .axi_slave_b_valid(b_valid), .axi_slave_b_resp(b_resp), .axi_slave_b_id(b_id),
    .axi_slave_b_ready(b_ready),
    .axi_slave_ar_valid(ar_valid), .axi_slave_ar_addr(ar_addr), .axi_slave_ar_len(ar_len),
    .axi_slave_ar_id(ar_id), .axi_slave_ar_ready(ar_ready),
    .axi_slave_r_valid(r_valid), .axi_slave_r_data(r_data), .axi_slave_r_resp(r_resp),
    .axi_slave_r_last(r_last), .axi_slave_r_id(r_id), .axi_slave_r_ready(r_ready)
  );

  function automatic bit inr(input logic [31:0] a);
    return a < LIMIT;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / NB) % WORDS);
  endfunction

  task automatic aw_hs(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] id);
    int n;
    @(negedge clk);
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_id = id;
    n = 0;
    while (!aw_ready && n < 100) begin @(negedge clk); n++; end
    if (!aw_ready) begin
      errors++; checks++;
      $display("FAIL aw_timeout: aw_ready=%0b required 1", aw_ready);
    end
    @(posedge clk); #1 aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] d, input logic [7:0] s);
    int n;
    @(negedge clk);
    w_valid = 1'b1; w_data = d; w_strb = s;
    n = 0;
    while (!w_ready && n < 100) begin @(negedge clk); n++; end
    if (!w_ready) begin
      errors++; checks++;
      $display("FAIL w_timeout: w_ready=%0b required 1", w_ready);
    end
    @(posedge clk); #1 w_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] id, input int b_delay);
    int n;
    bit err;
    logic [31:0] a;
    logic [1:0] exp_resp;
    err = 1'b0;
    aw_hs(addr, len, id);
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 32'(b * NB);
      w_send(wdat[b], wstb[b]);
      if (inr(a)) begin
        for (int i = 0; i < NB; i++)
          if (wstb[b][i]) model_mem[widx(a)][8*i +: 8] = wdat[b][8*i +: 8];
      end else err = 1'b1;
    end
    exp_resp = err ? 2'b10 : 2'b00;
    @(negedge clk);
    n = 0;
    while (!b_valid && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (b_valid !== 1'b1 || b_resp !== exp_resp || b_id !== id) begin
      errors++;
      $display("FAIL b_response @%h: valid=%b resp=%b id=%0d required valid=1 resp=%b id=%0d",
               addr, b_valid, b_resp, b_id, exp_resp, id);
    end
    for (int k = 0; k < b_delay; k++) begin
      @(negedge clk);
      checks++;
      if (b_valid !== 1'b1 || aw_ready !== 1'b0 || b_resp !== exp_resp) begin
        errors++;
        $display("FAIL b_hold cycle%0d: b_valid=%b aw_ready=%b resp=%b required 1 0 %b",
                 k, b_valid, aw_ready, b_resp, exp_resp);
      end
    end
    b_ready = 1'b1;
    @(posedge clk); #1 b_ready = 1'b0;
    b_done_time = $time;
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] id, input int hold_max);
    int n, hold;
    bit err;
    logic [31:0] a;
    logic [63:0] exp_d;
    logic exp_last;
    logic [1:0] exp_resp;
    err = 1'b0;
    ar_valid = 1'b0;
    @(negedge clk);
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_id = id;
    n = 0;
    while (!ar_ready && n < 100) begin @(negedge clk); n++; end
    if (!ar_ready) begin
      errors++; checks++;
      $display("FAIL ar_timeout: ar_ready=%0b required 1", ar_ready);
    end
    @(posedge clk); #1 ar_valid = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      a = addr + 32'(b * NB);
      if (!inr(a)) err = 1'b1;
      exp_d    = inr(a) ? model_mem[widx(a)] : 64'h0;
      exp_last = (b == int'(len));
      exp_resp = err ? 2'b10 : 2'b00;
      n = 0;
      do begin @(negedge clk); n++; end while (!r_valid && n < 50);
      checks++;
      if (n != 2) begin
        errors++;
        $display("FAIL r_latency beat%0d: r_valid after %0d cycles required 2", b, n);
      end
      checks++;
      if (r_data !== exp_d || r_resp !== exp_resp || r_last !== exp_last || r_id !== id) begin
        errors++;
        $display("FAIL r_beat%0d @%h: data=%h resp=%b last=%b id=%0d required %h %b %b %0d",
                 b, a, r_data, r_resp, r_last, r_id, exp_d, exp_resp, exp_last, id);
      end
      last_rdata = r_data;
      hold = $urandom_range(0, hold_max);
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b1 || r_data !== exp_d || r_last !== exp_last) begin
          errors++;
          $display("FAIL r_stable beat%0d: valid=%b data=%h last=%b required 1 %h %b",
                   b, r_valid, r_data, r_last, exp_d, exp_last);
        end
      end
      r_ready = 1'b1;
      @(posedge clk); #1 r_ready = 1'b0;
    end
    r_done_time = $time;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1 || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: aw=%b ar=%b w=%b required 1 1 0", aw_ready, ar_ready, w_ready);
    end
    checks++;
    if (b_valid !== 1'b0 || r_valid !== 1'b0 || r_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: b=%b r=%b last=%b required 0 0 0", b_valid, r_valid, r_last);
    end
    checks++;
    if (b_resp !== 2'b00 || b_id !== 3'd0 || r_resp !== 2'b00 || r_id !== 3'd0 || r_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_payload: bresp=%b bid=%0d rresp=%b rid=%0d rdata=%h required zeros",
               b_resp, b_id, r_resp, r_id, r_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_idle: aw=%b ar=%b required 1 1", aw_ready, ar_ready);
    end
  endtask

  task automatic test_basic();
    wdat[0] = 64'h1122334455667788; wstb[0] = 8'hFF;
    do_write(32'h0, 8'd0, 3'd1, 0);
    do_read(32'h0, 8'd0, 3'd2, 0);
    checks++;
    if (last_rdata !== 64'h1122334455667788) begin
      errors++;
      $display("FAIL basic_read: got %h required 1122334455667788", last_rdata);
    end
    wdat[0] = 64'hAAAAAAAAAAAAAAAA; wstb[0] = 8'h0F;
    do_write(32'h0, 8'd0, 3'd3, 0);
    do_read(32'h0, 8'd0, 3'd4, 2);
    checks++;
    if (last_rdata !== 64'h11223344AAAAAAAA) begin
      errors++;
      $display("FAIL strobe_read: got %h required 11223344aaaaaaaa", last_rdata);
    end
  endtask

  task automatic test_burst();
    for (int b = 0; b < 4; b++) begin wdat[b] = 64'(b + 1); wstb[b] = 8'hFF; end
    do_write(32'h100, 8'd3, 3'd5, 0);
    do_read(32'h100, 8'd3, 3'd6, 3);
  endtask

  task automatic test_out_of_range();
    wdat[0] = {$urandom, $urandom}; wstb[0] = 8'hFF;
    do_write(32'h2000, 8'd0, 3'd2, 0);
    do_read(32'h2000, 8'd0, 3'd1, 0);
    do_read(32'h0, 8'd0, 3'd0, 0);
    checks++;
    if (last_rdata !== 64'h11223344AAAAAAAA) begin
      errors++;
      $display("FAIL oob_alias: word0=%h required 11223344aaaaaaaa", last_rdata);
    end
    wdat[0] = {$urandom, $urandom}; wdat[1] = {$urandom, $urandom};
    wstb[0] = 8'hFF; wstb[1] = 8'hFF;
    do_write(32'h1FF8, 8'd1, 3'd7, 0);
    do_read(32'h1FF8, 8'd1, 3'd3, 1);
  endtask

  task automatic test_concurrent();
    wdat[0] = {$urandom, $urandom}; wstb[0] = 8'hFF;
    fork
      do_write(32'h200, 8'd0, 3'd7, 10);
      do_read(32'h100, 8'd0, 3'd3, 0);
    join
    checks++;
    if (!(r_done_time < b_done_time)) begin
      errors++;
      $display("FAIL concurrent_order: r_done=%0t b_done=%0t required r before b", r_done_time, b_done_time);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] d1;
    d1 = {$urandom, $urandom};
    aw_hs(32'h300, 8'd3, 3'd2);
    w_send(d1, 8'hFF);
    model_mem[widx(32'h300)] = d1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (aw_ready !== 1'b1 || ar_ready !== 1'b1 || w_ready !== 1'b0 || b_valid !== 1'b0 || r_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: aw=%b ar=%b w=%b b=%b r=%b required 1 1 0 0 0",
               aw_ready, ar_ready, w_ready, b_valid, r_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (aw_ready !== 1'b1 || w_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_release: aw=%b w=%b required 1 0", aw_ready, w_ready);
    end
    do_read(32'h300, 8'd0, 3'd1, 0);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    logic [7:0] len;
    for (int it = 0; it < 20; it++) begin
      addr = 32'($urandom_range(0, 1000) * NB + $urandom_range(0, 7));
      len  = 8'($urandom_range(0, 7));
      for (int b = 0; b <= int'(len); b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'hFF; end
      do_write(addr, len, 3'($urandom), 0);
      for (int b = 0; b <= int'(len); b++) begin wdat[b] = {$urandom, $urandom}; wstb[b] = 8'($urandom); end
      do_write(addr, len, 3'($urandom), $urandom_range(0, 2));
      do_read(addr, len, 3'($urandom), 2);
    end
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      wdat[0] = {$urandom, $urandom}; wstb[0] = 8'hFF;
      do_write(32'h400 + 32'(it * NB), 8'd0, 3'(it), 0);
    end
    do_read(32'h400, 8'd3, 3'd5, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_burst();
    test_out_of_range();
    test_concurrent();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
